// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared single-port memory between an instruction-fetch port and a data port.
// Data wins by default; a waiting fetch is forced through after STARVE_LIMIT data grants.
module mem_port_arbiter #(
   parameter int unsigned WORD_SIZE    = 16,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 InstrReq,
   input  logic [WORD_SIZE-1:0] InstrAddr,
   output logic [WORD_SIZE-1:0] InstrRdata,
   output logic                 InstrWaitreq,
   input  logic                 ReadData,
   input  logic                 WriteData,
   input  logic [WORD_SIZE-1:0] DataAddr,
   input  logic [WORD_SIZE-1:0] DataOut,
   output logic [WORD_SIZE-1:0] DataIn,
   output logic                 DataWaitreq,
   output logic [WORD_SIZE-1:0] MemAddr,
   output logic [WORD_SIZE-1:0] MemWdata,
   output logic                 MemRead,
   output logic                 MemWrite,
   input  logic [WORD_SIZE-1:0] MemRdata,
   input  logic                 MemWaitreq
);

   localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StInstr, StData} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      starve_q, starve_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic                 write_q, write_d;

   logic data_pend, fetch_pend, done, arbitrate;

   assign data_pend  = ReadData | WriteData;
   assign fetch_pend = InstrReq;
   assign done       = (state_q != StIdle) && !MemWaitreq;
   assign arbitrate  = (state_q == StIdle) || done;

   always_comb begin
      starve_d = starve_q;
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;

      if (done && state_q == StInstr) begin
         starve_d = '0;
      end else if (done && state_q == StData && InstrReq && starve_q != CntMax) begin
         starve_d = starve_q + 1'b1;
      end

      // Arbitrate on the updated count so the fetch wins right after the limit-th data grant.
      if (arbitrate) begin
         if (data_pend && (!fetch_pend || starve_d < CntMax)) begin
            state_d = StData;
            addr_d  = DataAddr;
            wdata_d = DataOut;
            write_d = WriteData;
         end else if (fetch_pend) begin
            state_d = StInstr;
            addr_d  = InstrAddr;
            wdata_d = '0;
            write_d = 1'b0;
         end else begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q  <= StIdle;
         starve_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
      end
   end

   assign MemAddr  = addr_q;
   assign MemWdata = wdata_q;
   assign MemRead  = (state_q == StInstr) || (state_q == StData && !write_q);
   assign MemWrite = (state_q == StData) && write_q;

   assign InstrWaitreq = InstrReq & ~((state_q == StInstr) & ~MemWaitreq);
   assign DataWaitreq  = data_pend & ~((state_q == StData) & ~MemWaitreq);

   assign InstrRdata = (state_q == StInstr) ? MemRdata : '0;
   assign DataIn     = (state_q == StData && !write_q) ? MemRdata : '0;

endmodule
